// File: rtl/ex_module_if.sv
// ---------------------------------------------------------------------------
// ex_module_if
// Bundles the ID/EX-register fields consumed by the execute stage together
// with everything the execute stage produces: the combinational branch outputs,
// the NZCV status fed back to decode, and the EX/MEM pipeline register outputs.
//   master  : decode side (drives instruction fields, observes EX results)
//   slave   : execute stage (consumes instruction fields, drives EX results)
// ---------------------------------------------------------------------------
interface ex_module_if;
    // Decoded instruction fields from the ID/EX register
    logic        wb_enable_in;
    logic        mem_read_enable_in;
    logic        mem_write_enable_in;
    logic        branch_enable;
    logic        S;
    logic [3:0]  exec_cmd;
    logic [31:0] PC;
    logic [31:0] Val_Rn;
    logic [31:0] Val_Rm;
    logic        immidiate;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_immidiate_24;
    logic [3:0]  Dest;

    // Execute-stage results
    logic        branch_taken;
    logic [31:0] branch_address;
    logic [3:0]  Status;
    logic        wb_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] ALU_result;
    logic [31:0] Val_Rm_out;
    logic [3:0]  Dest_out;

    modport master (
        output wb_enable_in, mem_read_enable_in, mem_write_enable_in,
               branch_enable, S, exec_cmd, PC, Val_Rn, Val_Rm, immidiate,
               Shift_operand, Signed_immidiate_24, Dest,
        input  branch_taken, branch_address, Status, wb_enable,
               mem_read_enable, mem_write_enable, ALU_result, Val_Rm_out,
               Dest_out
    );

    modport slave (
        input  wb_enable_in, mem_read_enable_in, mem_write_enable_in,
               branch_enable, S, exec_cmd, PC, Val_Rn, Val_Rm, immidiate,
               Shift_operand, Signed_immidiate_24, Dest,
        output branch_taken, branch_address, Status, wb_enable,
               mem_read_enable, mem_write_enable, ALU_result, Val_Rm_out,
               Dest_out
    );
endinterface

// File: rtl/ex_module.sv
// ---------------------------------------------------------------------------
// ex_module
// Execute stage of the 5-stage ARM-subset pipeline. Builds Val2 from the
// shifter operand, runs the ALU, computes the branch target, owns the NZCV
// status register and latches results into the EX/MEM pipeline register.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (clears EX/MEM and Status)
//   freeze : memory stall; EX/MEM register and Status hold their values
//   bus    : ex_module_if.slave - instruction fields in, EX results out
// Only WIDTH = 32 is supported.
// ---------------------------------------------------------------------------
module ex_module #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    ex_module_if.slave  bus
);
    // Rotate right; a rotate of 0 yields x because x << 32 is 0.
    function automatic logic [WIDTH-1:0] ror32(input logic [WIDTH-1:0] x,
                                               input logic [4:0]       r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       status_d, status_q;
    logic [WIDTH:0]   wide;       // 33-bit add/sub result, bit 32 is carry/borrow
    logic             c_in;

    logic             wb_enable_q, mem_read_enable_q, mem_write_enable_q;
    logic [WIDTH-1:0] alu_result_q, val_rm_q;
    logic [3:0]       dest_q;

    assign c_in = status_q[1];

    // ---------------- Val2 generation ----------------
    always_comb begin
        val2 = '0;
        if (bus.immidiate) begin
            val2 = ror32({24'd0, bus.Shift_operand[7:0]},
                         {bus.Shift_operand[11:8], 1'b0});
        end else if (bus.mem_read_enable_in || bus.mem_write_enable_in) begin
            val2 = {20'd0, bus.Shift_operand};
        end else begin
            case (bus.Shift_operand[6:5])
                2'b00:   val2 = bus.Val_Rm << bus.Shift_operand[11:7];
                2'b01:   val2 = bus.Val_Rm >> bus.Shift_operand[11:7];
                2'b10:   val2 = $signed(bus.Val_Rm) >>> bus.Shift_operand[11:7];
                default: val2 = ror32(bus.Val_Rm, bus.Shift_operand[11:7]);
            endcase
        end
    end

    // ---------------- ALU and next NZCV ----------------
    always_comb begin
        alu_res  = '0;
        wide     = '0;
        status_d = status_q;    // undefined commands leave every flag alone
        case (bus.exec_cmd)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                // ADD / ADC
                wide = {1'b0, bus.Val_Rn} + {1'b0, val2}
                     + {32'd0, (bus.exec_cmd[0] & c_in)};
                alu_res     = wide[WIDTH-1:0];
                status_d[1] = wide[WIDTH];
                status_d[0] = (bus.Val_Rn[31] == val2[31]) &&
                              (alu_res[31] != bus.Val_Rn[31]);
            end
            4'b0100, 4'b0101: begin
                // SUB / SBC; bit 32 set means a borrow occurred, C = NOT borrow
                wide = {1'b0, bus.Val_Rn} - {1'b0, val2}
                     - {32'd0, (bus.exec_cmd[0] & ~c_in)};
                alu_res     = wide[WIDTH-1:0];
                status_d[1] = ~wide[WIDTH];
                status_d[0] = (bus.Val_Rn[31] != val2[31]) &&
                              (alu_res[31] != bus.Val_Rn[31]);
            end
            4'b0110: alu_res = bus.Val_Rn & val2;
            4'b0111: alu_res = bus.Val_Rn | val2;
            4'b1000: alu_res = bus.Val_Rn ^ val2;
            default: alu_res = '0;
        endcase

        // N and Z follow the result for every defined command
        if (bus.exec_cmd != 4'b0000 && (bus.exec_cmd <= 4'b1001)) begin
            status_d[3] = alu_res[31];
            status_d[2] = ~|alu_res;
        end
    end

    // ---------------- EX/MEM and status registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q           <= '0;
            wb_enable_q        <= 1'b0;
            mem_read_enable_q  <= 1'b0;
            mem_write_enable_q <= 1'b0;
            alu_result_q       <= '0;
            val_rm_q           <= '0;
            dest_q             <= '0;
        end else if (!freeze) begin
            if (bus.S) begin
                status_q <= status_d;
            end
            wb_enable_q        <= bus.wb_enable_in;
            mem_read_enable_q  <= bus.mem_read_enable_in;
            mem_write_enable_q <= bus.mem_write_enable_in;
            alu_result_q       <= alu_res;
            val_rm_q           <= bus.Val_Rm;
            dest_q             <= bus.Dest;
        end
    end

    // Branch target is combinational and intentionally not gated by freeze.
    assign bus.branch_taken   = bus.branch_enable;
    assign bus.branch_address = bus.PC + {{6{bus.Signed_immidiate_24[23]}},
                                          bus.Signed_immidiate_24, 2'b00};

    assign bus.Status           = status_q;
    assign bus.wb_enable        = wb_enable_q;
    assign bus.mem_read_enable  = mem_read_enable_q;
    assign bus.mem_write_enable = mem_write_enable_q;
    assign bus.ALU_result       = alu_result_q;
    assign bus.Val_Rm_out       = val_rm_q;
    assign bus.Dest_out         = dest_q;
endmodule

// File: tb/tb_ex_module.sv
module tb_ex_module;
    logic clk;
    logic rst;
    logic freeze;
    int   errors = 0;
    int   checks = 0;

    ex_module_if bus();

    ex_module #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] cmd, input logic s, input logic imm,
                             input logic [11:0] so, input logic [31:0] rn,
                             input logic [31:0] rm, input logic mr, input logic mw,
                             input logic wb, input logic [3:0] dest);
        bus.exec_cmd            = cmd;
        bus.S                   = s;
        bus.immidiate           = imm;
        bus.Shift_operand       = so;
        bus.Val_Rn              = rn;
        bus.Val_Rm              = rm;
        bus.mem_read_enable_in  = mr;
        bus.mem_write_enable_in = mw;
        bus.wb_enable_in        = wb;
        bus.Dest                = dest;
        $display("[%0t] issue cmd=%b S=%b I=%b so=%h rn=%h rm=%h mr=%b mw=%b freeze=%b",
                 $time, cmd, s, imm, so, rn, rm, mr, mw, freeze);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        freeze = 1'b0;
        bus.branch_enable = 1'b0;
        bus.PC = 32'h0;
        bus.Signed_immidiate_24 = 24'h0;
        set_instr(4'b0001, 1'b1, 1'b1, 12'h0FF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h3);
        #2;
        checks++;
        if ({bus.Status, bus.wb_enable, bus.mem_read_enable, bus.mem_write_enable,
             bus.ALU_result, bus.Val_Rm_out, bus.Dest_out} !== 75'd0) begin
            errors++;
            $display("FAIL reset_state: status=%b alu=%h dest=%h required all zero",
                     bus.Status, bus.ALU_result, bus.Dest_out);
        end
        step();
        checks++;
        if (bus.ALU_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_hold: alu=%h required 0", bus.ALU_result);
        end
        rst = 1'b0;
    endtask

    task automatic test_add_flags();
        set_instr(4'b0010, 1'b1, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0, 1'b1, 4'h5);
        step();
        checks++;
        if (bus.ALU_result !== 32'h80000000 || bus.Status !== 4'b1001) begin
            errors++;
            $display("FAIL add_overflow: alu=%h status=%b required 80000000 1001",
                     bus.ALU_result, bus.Status);
        end
        checks++;
        if (bus.wb_enable !== 1'b1 || bus.Dest_out !== 4'h5) begin
            errors++;
            $display("FAIL add_ctrl: wb=%b dest=%h required 1 5", bus.wb_enable, bus.Dest_out);
        end
    endtask

    task automatic test_imm_rotate_sub();
        set_instr(4'b0001, 1'b0, 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h1);
        step();
        checks++;
        if (bus.ALU_result !== 32'hFF000000 || bus.Status !== 4'b1001) begin
            errors++;
            $display("FAIL mov_rotate: alu=%h status=%b required ff000000 1001",
                     bus.ALU_result, bus.Status);
        end
        set_instr(4'b0100, 1'b1, 1'b1, 12'h005, 32'h5, 32'h0, 1'b0, 1'b0, 1'b1, 4'h1);
        step();
        checks++;
        if (bus.ALU_result !== 32'h0 || bus.Status !== 4'b0110) begin
            errors++;
            $display("FAIL sub_zero: alu=%h status=%b required 0 0110",
                     bus.ALU_result, bus.Status);
        end
    endtask

    task automatic test_shifts();
        logic [11:0] so_tab [5] = '{12'h240, 12'h460, 12'hF80, 12'hFA0, 12'h060};
        logic [31:0] rm_tab [5] = '{32'h80000000, 32'h000000AB, 32'h1, 32'h80000000, 32'h12345678};
        logic [31:0] ex_tab [5] = '{32'hF8000000, 32'hAB000000, 32'h80000000, 32'h1, 32'h12345678};
        for (int i = 0; i < 5; i++) begin
            set_instr(4'b0001, 1'b0, 1'b0, so_tab[i], 32'h0, rm_tab[i], 1'b0, 1'b0, 1'b1, 4'h2);
            step();
            checks++;
            if (bus.ALU_result !== ex_tab[i]) begin
                errors++;
                $display("FAIL shift_%0d: alu=%h required %h", i, bus.ALU_result, ex_tab[i]);
            end
        end
    endtask

    task automatic test_mem_freeze();
        set_instr(4'b0010, 1'b0, 1'b0, 12'h804, 32'h1000, 32'h0, 1'b1, 1'b0, 1'b1, 4'h4);
        step();
        checks++;
        if (bus.ALU_result !== 32'h1804 || bus.mem_read_enable !== 1'b1 || bus.Status !== 4'b0110) begin
            errors++;
            $display("FAIL ldr_addr: alu=%h mr=%b status=%b required 1804 1 0110",
                     bus.ALU_result, bus.mem_read_enable, bus.Status);
        end
        freeze = 1'b1;
        // An instruction that would change flags and result must be ignored
        set_instr(4'b0100, 1'b1, 1'b1, 12'h001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h9);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.ALU_result !== 32'h1804 || bus.Status !== 4'b0110 ||
                bus.mem_read_enable !== 1'b1 || bus.Dest_out !== 4'h4) begin
                errors++;
                $display("FAIL freeze_hold_%0d: alu=%h status=%b dest=%h required 1804 0110 4",
                         i, bus.ALU_result, bus.Status, bus.Dest_out);
            end
        end
        freeze = 1'b0;
        set_instr(4'b0010, 1'b0, 1'b0, 12'h010, 32'h2000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4'h0);
        step();
        checks++;
        if (bus.ALU_result !== 32'h2010 || bus.Val_Rm_out !== 32'hDEADBEEF ||
            bus.mem_write_enable !== 1'b1 || bus.wb_enable !== 1'b0) begin
            errors++;
            $display("FAIL str: alu=%h data=%h mw=%b wb=%b required 2010 deadbeef 1 0",
                     bus.ALU_result, bus.Val_Rm_out, bus.mem_write_enable, bus.wb_enable);
        end
    endtask

    task automatic test_branch_adc();
        bus.PC = 32'h100;
        bus.Signed_immidiate_24 = 24'hFFFFFE;
        bus.branch_enable = 1'b1;
        freeze = 1'b1;
        #1;
        checks++;
        if (bus.branch_address !== 32'hF8 || bus.branch_taken !== 1'b1) begin
            errors++;
            $display("FAIL branch_back: addr=%h taken=%b required f8 1",
                     bus.branch_address, bus.branch_taken);
        end
        freeze = 1'b0;
        bus.Signed_immidiate_24 = 24'h000010;
        bus.branch_enable = 1'b0;
        #1;
        checks++;
        if (bus.branch_address !== 32'h140 || bus.branch_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_fwd: addr=%h taken=%b required 140 0",
                     bus.branch_address, bus.branch_taken);
        end
        set_instr(4'b0011, 1'b0, 1'b1, 12'h001, 32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 4'h6);
        step();
        checks++;
        if (bus.ALU_result !== 32'h3) begin
            errors++;
            $display("FAIL adc_carry: alu=%h required 3", bus.ALU_result);
        end
    endtask

    task automatic test_logic_ops();
        logic [3:0]  cmd_tab [9] = '{4'b0100, 4'b0101, 4'b0100, 4'b0110, 4'b1001,
                                     4'b0111, 4'b1000, 4'b0000, 4'b0010};
        logic        s_tab   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] so_tab  [9] = '{12'h001, 12'h003, 12'h001, 12'h00F, 12'h000,
                                     12'h00F, 12'h00F, 12'h001, 12'h001};
        logic [31:0] rn_tab  [9] = '{32'h0, 32'hA, 32'h80000000, 32'hF0, 32'h0,
                                     32'hF0, 32'hFF, 32'hFF, 32'hFFFFFFFF};
        logic [31:0] ex_tab  [9] = '{32'hFFFFFFFF, 32'h6, 32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF,
                                     32'hFF, 32'hF0, 32'h0, 32'h0};
        logic [3:0]  st_tab  [9] = '{4'b1000, 4'b0010, 4'b0011, 4'b0111, 4'b1011,
                                     4'b1011, 4'b1011, 4'b1011, 4'b0110};
        for (int i = 0; i < 9; i++) begin
            set_instr(cmd_tab[i], s_tab[i], 1'b1, so_tab[i], rn_tab[i], 32'h0,
                      1'b0, 1'b0, 1'b1, 4'h7);
            step();
            checks++;
            if (bus.ALU_result !== ex_tab[i] || bus.Status !== st_tab[i]) begin
                errors++;
                $display("FAIL alu_op_%0d: alu=%h status=%b required %h %b",
                         i, bus.ALU_result, bus.Status, ex_tab[i], st_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_instr(4'b0001, 1'b1, 1'b1, 12'h0AA, 32'h0, 32'h55, 1'b0, 1'b0, 1'b1, 4'hC);
        step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.Status, bus.wb_enable, bus.mem_read_enable, bus.mem_write_enable,
             bus.ALU_result, bus.Val_Rm_out, bus.Dest_out} !== 75'd0) begin
            errors++;
            $display("FAIL reset_async: status=%b alu=%h rm=%h dest=%h required all zero",
                     bus.Status, bus.ALU_result, bus.Val_Rm_out, bus.Dest_out);
        end
        #1 rst = 1'b0;
        set_instr(4'b0001, 1'b0, 1'b1, 12'h012, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'h8);
        step();
        checks++;
        if (bus.ALU_result !== 32'h12 || bus.Status !== 4'b0000 || bus.Dest_out !== 4'h8) begin
            errors++;
            $display("FAIL reset_resume: alu=%h status=%b dest=%h required 12 0000 8",
                     bus.ALU_result, bus.Status, bus.Dest_out);
        end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_imm_rotate_sub();
        test_shifts();
        test_mem_freeze();
        test_branch_adc();
        test_logic_ops();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_module.md
Name: ex_module

Overview:
- Execute stage of the 5-stage ARM-subset pipeline.
- Consumes the decoded, registered outputs of the decode stage and generates Val2 from the shifter operand.
- Performs the ALU operation, computes the branch target, and owns the NZCV status register.
- Latches results into the EX/MEM pipeline register; status register output feeds back to decode for condition checking.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- freeze  in  1  memory-stall hold; EX/MEM register and status register keep their values
- wb_enable_in  in  1  writeback enable from decode register
- mem_read_enable_in  in  1  load
- mem_write_enable_in  in  1  store
- branch_enable  in  1  branch decoded and condition passed
- S  in  1  update status flags
- exec_cmd  in  4  ALU command
- PC  in  32  PC+4 of this instruction
- Val_Rn  in  32  first operand
- Val_Rm  in  32  register operand / store data
- immidiate  in  1  I bit
- Shift_operand  in  12  shifter operand field
- Signed_immidiate_24  in  24  branch offset
- Dest  in  4  destination register
- branch_taken  out  1  combinational, equals branch_enable
- branch_address  out  32  combinational, PC + (sign-extended imm24 << 2)
- Status  out  4  registered NZCV: [3]N [2]Z [1]C [0]V
- wb_enable  out  1  registered
- mem_read_enable  out  1  registered
- mem_write_enable  out  1  registered
- ALU_result  out  32  registered
- Val_Rm_out  out  32  registered store data
- Dest_out  out  4  registered

Behaviour:
- Reset (async, rst=1): all registered outputs and Status = 0 immediately, independent of clk. Takes priority over freeze.
- Latency: one cycle; inputs at edge N appear on the EX/MEM outputs after edge N+1.
- Val2 selection, priority order:
  - immidiate=1: zero-extend Shift_operand[7:0] to 32 bits, rotate right by 2*Shift_operand[11:8]. A rotate of 0 passes the value unchanged.
  - else if mem_read_enable_in or mem_write_enable_in: zero-extend Shift_operand[11:0].
  - else shift Val_Rm by Shift_operand[11:7], type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes Val_Rm unchanged.
- ALU operations (exec_cmd):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-(1-C)
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR
  - 1000 EOR
  - any other code: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add ops: C = bit 32 of the 33-bit sum; V = operands same sign and result sign differs.
  - Subtract ops: C = NOT borrow; V = operand signs differ and result sign differs from Rn.
  - Logic, MOV, MVN: C and V unchanged.
- Status register: loads the new NZCV on a rising edge when S=1 and freeze=0; otherwise holds. The C used by ADC/SBC is the registered Status[1] (current value, before this instruction's update).
- EX/MEM register: loads on every rising edge with freeze=0; holds all outputs while freeze=1.
- Branch outputs are combinational and are not gated by freeze. Flushing of younger stages is handled upstream; this block does not self-flush.
- Arithmetic wraps modulo 2^32. Branch offset is sign-extended from bit 23 and may be negative.

Test Plan:
- Reset mid-operation: assert rst between edges -> all outputs and Status = 0 without waiting for a clock edge; deassert rst -> next instruction latches normally.
- ADD with S=1: Rn=0x7FFFFFFF, immidiate=1, Shift_operand=0x001 -> ALU_result=0x80000000, Status=1001 (N,V) after one edge.
- Immediate rotate: MOV, Shift_operand=0x4FF -> Val2=0xFF000000; SUB Rn=5, Val2=5, S=1 -> ALU_result=0, Status=0110 (Z,C).
- Register shift: MOV, Val_Rm=0x80000000, ASR #4 (Shift_operand=0x240) -> ALU_result=0xF8000000. ROR #8 of 0x000000AB -> 0xAB000000.
- Memory address: LDR (exec_cmd=0010, mem_read=1), Rn=0x1000, Shift_operand=0x804 -> ALU_result=0x1804. Freeze held 3 cycles -> outputs unchanged and Status unchanged.
- Branch: PC=0x100, imm24=0xFFFFFE -> branch_address=0xF8, branch_taken=1 in the same cycle. Then ADC with C=1, Rn=1, Val2=1 -> ALU_result=3.
